// File: rtl/spu_mast_stq_pkg.sv
// Shared definitions for the MA store-request queue: sizes, entry layout, FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spu_mast_stq_pkg;

    localparam int STQ_DEPTH  = 2;   // queue entries; pointers are 1 bit plus a wrap bit
    localparam int STQ_OCNT_W = 4;   // outstanding-at-L2 store counter width
    localparam int PA_W       = 37;  // PA[39:3], one 8-byte word per address
    localparam int DATA_W     = 64;

    // One queued store: the MPA captured at push time plus the MA memory word.
    typedef struct packed {
        logic [PA_W-1:0]   addr;
        logic [DATA_W-1:0] data;
    } stq_entry_t;

    // One-hot store-request FSM.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_REQ  = 3'b010,
        ST_ACK  = 3'b100
    } stq_state_t;

endpackage

// File: rtl/spu_stq_fifo.sv
// Small register FIFO; head is combinational from storage (entry visible the cycle after push).
// Latency: push at N is at head in N+1; pop takes effect on the clock edge.
// Backpressure: push while full is dropped unless a pop happens the same cycle; pop while empty is ignored.
//
// Ports: rclk/rst_l clock and async active-low reset; push/push_dat write; pop removes head;
//        flush empties the queue (wins over push/pop); full/empty status; head_dat oldest entry.
module spu_stq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2     // must be a power of two so pointer wrap is free
) (
    input  logic         rclk,
    input  logic         rst_l,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_dat
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         push_ok;
    logic         pop_ok;

    // Same index with opposite wrap bits means every slot is occupied.
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign pop_ok   = pop && !empty;
    // At full, a same-cycle pop frees the head slot, so the write may reuse it.
    assign push_ok  = push && (!full || pop_ok);
    assign head_dat = mem[rptr[AW-1:0]];

    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push_ok && !flush) begin
            mem[wptr[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/spu_mast_stq.sv
// MA store-request queue: tags MA read words with the MPA, issues one LSU store per sequencer request.
// Latency: streq with a non-empty queue -> spu_lsu_st_req next cycle; lsu_st_ack -> stq_streq_ack next cycle.
// Backpressure: request held with stable addr/data until lsu_st_ack; queue overflow drops the push and sets stq_err.
//
// Ports: rclk/rst_l clock and async active-low reset; se scan enable (no functional use);
//        mast_stbuf_wen/stbuf_din queue push; mpa_ld/mpa_din/mast_mpa_addrinc MPA control;
//        mast_streq store request; mactl_abort flush; lsu_st_ack/lsu_st_cmplt LSU handshake and L2 completion;
//        spu_lsu_st_req/addr/data store to LSU; stq_streq_ack sequencer ack; stq_allma_stacks_ok all stores drained;
//        stq_err sticky error.
module spu_mast_stq
    import spu_mast_stq_pkg::*;
#(
    parameter int DEPTH  = STQ_DEPTH,
    parameter int OCNT_W = STQ_OCNT_W
) (
    input  logic              rclk,
    input  logic              rst_l,
    input  logic              se,
    input  logic              mast_stbuf_wen,
    input  logic [DATA_W-1:0] stbuf_din,
    input  logic              mpa_ld,
    input  logic [PA_W-1:0]   mpa_din,
    input  logic              mast_mpa_addrinc,
    input  logic              mast_streq,
    input  logic              mactl_abort,
    input  logic              lsu_st_ack,
    input  logic              lsu_st_cmplt,
    output logic              spu_lsu_st_req,
    output logic [PA_W-1:0]   spu_lsu_st_addr,
    output logic [DATA_W-1:0] spu_lsu_st_data,
    output logic              stq_streq_ack,
    output logic              stq_allma_stacks_ok,
    output logic              stq_err
);

    localparam logic [OCNT_W-1:0] OCNT_MAX = '1;

    logic [PA_W-1:0]   mpa;
    stq_entry_t        wr_entry;
    stq_entry_t        q_head;
    logic              q_full;
    logic              q_empty;
    logic              q_pop;
    stq_state_t        state;
    logic [1:0]        pend;
    logic [OCNT_W-1:0] ocnt;
    logic              abort_seen;

    logic              start_req;
    logic              st_accept;
    logic              q_ovf;
    logic              pend_ovf;
    logic              ocnt_err;

    // Scan enable has no functional effect in this block.
    logic              unused_se;
    assign unused_se = se;

    // ------------------------------------------------------------------
    // MPA register: load has priority over increment.
    // ------------------------------------------------------------------
    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            mpa <= '0;
        end else if (mpa_ld) begin
            mpa <= mpa_din;
        end else if (mast_mpa_addrinc) begin
            mpa <= mpa + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Store queue
    // ------------------------------------------------------------------
    assign wr_entry = '{addr: mpa, data: stbuf_din};

    spu_stq_fifo #(
        .W     ($bits(stq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .rclk     (rclk),
        .rst_l    (rst_l),
        .push     (mast_stbuf_wen),
        .push_dat (wr_entry),
        .pop      (q_pop),
        .flush    (mactl_abort),
        .full     (q_full),
        .empty    (q_empty),
        .head_dat (q_head)
    );

    // A same-cycle streq counts toward pending so the request goes out the next cycle.
    assign start_req = (state == ST_IDLE) && !mactl_abort && !q_empty &&
                       ((pend != 2'd0) || mast_streq);
    assign st_accept = (state == ST_REQ) && lsu_st_ack;
    // After an abort flush the queue may already be empty when the LSU acks; the fifo ignores that pop.
    assign q_pop     = st_accept;

    assign q_ovf     = mast_stbuf_wen && q_full && !q_pop && !mactl_abort;
    assign pend_ovf  = mast_streq && !start_req && (pend == 2'd3) && !mactl_abort;
    assign ocnt_err  = (lsu_st_cmplt && !st_accept && (ocnt == '0)) ||
                       (st_accept && !lsu_st_cmplt && (ocnt == OCNT_MAX));

    // ------------------------------------------------------------------
    // Pending sequencer requests: +1 per streq, -1 as each request is issued.
    // ------------------------------------------------------------------
    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            pend <= 2'd0;
        end else if (mactl_abort) begin
            pend <= 2'd0;
        end else begin
            case ({mast_streq, start_req})
                2'b10:   if (pend != 2'd3) pend <= pend + 2'd1;
                2'b01:   pend <= pend - 2'd1;
                default: pend <= pend;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Request FSM. Address/data are captured on entry to REQ so they stay
    // stable even if an abort flushes the queue under a live request.
    // ------------------------------------------------------------------
    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            state           <= ST_IDLE;
            spu_lsu_st_req  <= 1'b0;
            stq_streq_ack   <= 1'b0;
            spu_lsu_st_addr <= '0;
            spu_lsu_st_data <= '0;
            abort_seen      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    stq_streq_ack <= 1'b0;
                    if (start_req) begin
                        state           <= ST_REQ;
                        spu_lsu_st_req  <= 1'b1;
                        spu_lsu_st_addr <= q_head.addr;
                        spu_lsu_st_data <= q_head.data;
                        abort_seen      <= 1'b0;
                    end
                end
                ST_REQ: begin
                    // The LSU request is never withdrawn; an abort only suppresses the sequencer ack.
                    if (lsu_st_ack) begin
                        spu_lsu_st_req <= 1'b0;
                        abort_seen     <= 1'b0;
                        if (mactl_abort || abort_seen) begin
                            state <= ST_IDLE;
                        end else begin
                            state         <= ST_ACK;
                            stq_streq_ack <= 1'b1;
                        end
                    end else if (mactl_abort) begin
                        abort_seen <= 1'b1;
                    end
                end
                ST_ACK: begin
                    stq_streq_ack <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: begin
                    state          <= ST_IDLE;
                    spu_lsu_st_req <= 1'b0;
                    stq_streq_ack  <= 1'b0;
                    abort_seen     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stores outstanding at L2. Not cleared by abort: in-flight stores still complete.
    // ------------------------------------------------------------------
    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            ocnt <= '0;
        end else begin
            case ({st_accept, lsu_st_cmplt})
                2'b10:   if (ocnt != OCNT_MAX) ocnt <= ocnt + 1'b1;
                2'b01:   if (ocnt != '0)       ocnt <= ocnt - 1'b1;
                default: ocnt <= ocnt;
            endcase
        end
    end

    assign stq_allma_stacks_ok = (ocnt == '0);

    // Sticky error: queue overflow, pending overflow, outstanding counter under/overflow.
    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            stq_err <= 1'b0;
        end else if (q_ovf || pend_ovf || ocnt_err) begin
            stq_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spu_mast_stq.sv
// Scoreboard bench for spu_mast_stq: expected stores queued at push time, checked by a negedge monitor.
// Latency: n/a.
// Backpressure: LSU modelled by directed tasks holding lsu_st_ack off for a chosen number of cycles.
module tb_spu_mast_stq;
    import spu_mast_stq_pkg::*;

    logic              rclk = 1'b0;
    logic              rst_l = 1'b0;
    logic              se = 1'b0;
    logic              mast_stbuf_wen = 1'b0;
    logic [DATA_W-1:0] stbuf_din = '0;
    logic              mpa_ld = 1'b0;
    logic [PA_W-1:0]   mpa_din = '0;
    logic              mast_mpa_addrinc = 1'b0;
    logic              mast_streq = 1'b0;
    logic              mactl_abort = 1'b0;
    logic              lsu_st_ack = 1'b0;
    logic              lsu_st_cmplt = 1'b0;
    logic              spu_lsu_st_req;
    logic [PA_W-1:0]   spu_lsu_st_addr;
    logic [DATA_W-1:0] spu_lsu_st_data;
    logic              stq_streq_ack;
    logic              stq_allma_stacks_ok;
    logic              stq_err;

    always #5 rclk = ~rclk;

    spu_mast_stq dut (
        .rclk                (rclk),
        .rst_l               (rst_l),
        .se                  (se),
        .mast_stbuf_wen      (mast_stbuf_wen),
        .stbuf_din           (stbuf_din),
        .mpa_ld              (mpa_ld),
        .mpa_din             (mpa_din),
        .mast_mpa_addrinc    (mast_mpa_addrinc),
        .mast_streq          (mast_streq),
        .mactl_abort         (mactl_abort),
        .lsu_st_ack          (lsu_st_ack),
        .lsu_st_cmplt        (lsu_st_cmplt),
        .spu_lsu_st_req      (spu_lsu_st_req),
        .spu_lsu_st_addr     (spu_lsu_st_addr),
        .spu_lsu_st_data     (spu_lsu_st_data),
        .stq_streq_ack       (stq_streq_ack),
        .stq_allma_stacks_ok (stq_allma_stacks_ok),
        .stq_err             (stq_err)
    );

    int              checks = 0;
    int              errors = 0;
    stq_entry_t      sb[$];
    logic [PA_W-1:0] exp_mpa = '0;
    int              exp_ocnt = 0;
    int              exp_acks = 0;
    int              ack_seen = 0;

    logic              mon_prev_req = 1'b0;
    logic              mon_prev_acc = 1'b0;
    logic              mon_prev_sack = 1'b0;
    logic [PA_W-1:0]   mon_prev_addr = '0;
    logic [DATA_W-1:0] mon_prev_data = '0;
    stq_entry_t        mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0b expected %0b", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares every accepted store against the scoreboard,
    // checks addr/data stability while a request is held, and counts acks.
    // ------------------------------------------------------------------
    always @(negedge rclk) begin
        if (!rst_l) begin
            mon_prev_req  = 1'b0;
            mon_prev_acc  = 1'b0;
            mon_prev_sack = 1'b0;
        end else begin
            if (spu_lsu_st_req && mon_prev_req && !mon_prev_acc) begin
                check("hold_addr", 64'(spu_lsu_st_addr), 64'(mon_prev_addr));
                check("hold_data", spu_lsu_st_data, mon_prev_data);
            end
            if (spu_lsu_st_req && lsu_st_ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL store_unexpected got addr %0h expected no store", spu_lsu_st_addr);
                end else begin
                    mon_e = sb.pop_front();
                    check("store_addr", 64'(spu_lsu_st_addr), 64'(mon_e.addr));
                    check("store_data", spu_lsu_st_data, mon_e.data);
                end
            end
            if (stq_streq_ack) begin
                ack_seen++;
                check1("ack_one_cycle", mon_prev_sack, 1'b0);
            end
            mon_prev_req  = spu_lsu_st_req;
            mon_prev_acc  = spu_lsu_st_req && lsu_st_ack;
            mon_prev_sack = stq_streq_ack;
            mon_prev_addr = spu_lsu_st_addr;
            mon_prev_data = spu_lsu_st_data;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic tick;
        @(posedge rclk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_req"},  spu_lsu_st_req, 1'b0);
        check1({tag, "_sack"}, stq_streq_ack, 1'b0);
        check1({tag, "_err"},  stq_err, 1'b0);
        check1({tag, "_ok"},   stq_allma_stacks_ok, 1'b1);
        check({tag, "_addr"},  64'(spu_lsu_st_addr), 64'h0);
        check({tag, "_data"},  spu_lsu_st_data, 64'h0);
    endtask

    task automatic do_reset;
        rst_l = 1'b0;
        sb.delete();
        exp_ocnt = 0;
        exp_mpa  = '0;
        repeat (2) tick;
        check_reset_outputs("reset");
        rst_l = 1'b1;
        tick;
    endtask

    task automatic mpa_load(input logic [PA_W-1:0] a, input logic inc);
        mpa_ld = 1'b1;
        mpa_din = a;
        mast_mpa_addrinc = inc;
        tick;
        mpa_ld = 1'b0;
        mast_mpa_addrinc = 1'b0;
        exp_mpa = a;
    endtask

    // keep=0 marks a push that must never reach the LSU (dropped, flushed or lost to reset).
    task automatic push(input logic [DATA_W-1:0] d, input logic inc, input logic keep);
        mast_stbuf_wen = 1'b1;
        stbuf_din = d;
        mast_mpa_addrinc = inc;
        if (keep) sb.push_back('{addr: exp_mpa, data: d});
        tick;
        mast_stbuf_wen = 1'b0;
        mast_mpa_addrinc = 1'b0;
        exp_mpa = exp_mpa + PA_W'(inc);
    endtask

    task automatic streq_pulse;
        mast_streq = 1'b1;
        tick;
        mast_streq = 1'b0;
    endtask

    task automatic cmplt;
        lsu_st_cmplt = 1'b1;
        tick;
        lsu_st_cmplt = 1'b0;
        if (exp_ocnt > 0) exp_ocnt--;
        check1("ok_after_cmplt", stq_allma_stacks_ok, exp_ocnt == 0);
    endtask

    // LSU model: wait (bounded) for a request, hold it 'hold' cycles, then ack.
    task automatic lsu_serve(input int hold, input logic with_cmplt, input logic exp_sack);
        int n;
        n = 0;
        while (!spu_lsu_st_req && n < 20) begin
            tick;
            n++;
        end
        check1("req_wait", spu_lsu_st_req, 1'b1);
        repeat (hold) tick;
        lsu_st_ack = 1'b1;
        lsu_st_cmplt = with_cmplt;
        tick;
        lsu_st_ack = 1'b0;
        lsu_st_cmplt = 1'b0;
        if (!with_cmplt) exp_ocnt++;
        if (exp_sack) exp_acks++;
        check1("sack_after_ack", stq_streq_ack, exp_sack);
        check1("req_drop_after_ack", spu_lsu_st_req, 1'b0);
        check1("ok_after_ack", stq_allma_stacks_ok, exp_ocnt == 0);
        tick;
        check1("sack_single", stq_streq_ack, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic store
        do_reset;
        mpa_load(37'h100, 1'b0);
        push(64'hD0D0_0000_0000_00D0, 1'b0, 1'b1);
        streq_pulse;
        check1("req_latency", spu_lsu_st_req, 1'b1);
        lsu_serve(0, 1'b0, 1'b1);
        cmplt;

        // Back-to-back with 3-cycle LSU hold; addresses 0x100 then 0x101
        push(64'h1111_2222_3333_4444, 1'b1, 1'b1);
        push(64'h5555_6666_7777_8888, 1'b0, 1'b1);
        streq_pulse;
        check1("b2b_req_latency", spu_lsu_st_req, 1'b1);
        streq_pulse;
        lsu_serve(3, 1'b0, 1'b1);
        lsu_serve(3, 1'b0, 1'b1);
        cmplt;
        cmplt;

        // Push+pop at full: legal, order preserved
        push(64'hE0E0_E0E0_E0E0_E0E0, 1'b0, 1'b1);
        push(64'hE1E1_E1E1_E1E1_E1E1, 1'b1, 1'b1);
        streq_pulse;
        check1("full_req", spu_lsu_st_req, 1'b1);
        mast_stbuf_wen = 1'b1;
        stbuf_din = 64'hE3E3_E3E3_E3E3_E3E3;
        sb.push_back('{addr: exp_mpa, data: 64'hE3E3_E3E3_E3E3_E3E3});
        lsu_st_ack = 1'b1;
        tick;
        mast_stbuf_wen = 1'b0;
        lsu_st_ack = 1'b0;
        exp_ocnt++;
        exp_acks++;
        check1("pushpop_full_err", stq_err, 1'b0);
        check1("pushpop_full_sack", stq_streq_ack, 1'b1);
        tick;
        streq_pulse;
        streq_pulse;
        lsu_serve(1, 1'b0, 1'b1);
        lsu_serve(1, 1'b0, 1'b1);

        // Overflow: third push dropped, sticky error
        push(64'hF0F0_0000_0000_0000, 1'b1, 1'b1);
        push(64'hF1F1_0000_0000_0000, 1'b1, 1'b1);
        push(64'hF2F2_0000_0000_0000, 1'b1, 1'b0);
        check1("overflow_err", stq_err, 1'b1);
        streq_pulse;
        streq_pulse;
        lsu_serve(0, 1'b0, 1'b1);
        lsu_serve(0, 1'b0, 1'b1);
        for (int i = 0; i < 16 && exp_ocnt > 0; i++) cmplt;

        // Abort in REQ; mpa_ld wins over a same-cycle increment
        do_reset;
        mpa_load(37'h200, 1'b1);
        push(64'h6060_0000_0000_0000, 1'b0, 1'b1);
        push(64'h6161_0000_0000_0000, 1'b0, 1'b0);
        streq_pulse;
        check("ld_wins_addr", 64'(spu_lsu_st_addr), 64'h200);
        mactl_abort = 1'b1;
        tick;
        mactl_abort = 1'b0;
        check1("abort_req_held", spu_lsu_st_req, 1'b1);
        tick;
        lsu_serve(0, 1'b0, 1'b0);
        streq_pulse;
        for (int i = 0; i < 3; i++) begin
            check1("abort_queue_empty", spu_lsu_st_req, 1'b0);
            tick;
        end
        cmplt;
        push(64'h4848_4848_0000_0000, 1'b0, 1'b1);
        lsu_serve(0, 1'b0, 1'b1);

        // Counter edges: ack+cmplt at count 1 holds 1; cmplt at 0 errors and holds 0
        push(64'hCAFE_0000_0000_0001, 1'b0, 1'b1);
        streq_pulse;
        lsu_serve(0, 1'b1, 1'b1);
        cmplt;
        check1("pre_underflow_err", stq_err, 1'b0);
        cmplt;
        check1("underflow_err", stq_err, 1'b1);
        push(64'hCAFE_0000_0000_0002, 1'b0, 1'b1);
        streq_pulse;
        lsu_serve(0, 1'b0, 1'b1);
        cmplt;

        // Reset mid-REQ with two entries queued
        push(64'hAAAA_0000_0000_0001, 1'b0, 1'b0);
        push(64'hAAAA_0000_0000_0002, 1'b0, 1'b0);
        streq_pulse;
        check1("pre_reset_req", spu_lsu_st_req, 1'b1);
        rst_l = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        tick;
        rst_l = 1'b1;
        tick;

        check("scoreboard_drained", 64'(sb.size()), 64'h0);
        check("ack_count", 64'(ack_seen), 64'(exp_acks));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
